// File: rtl/suite_pkg.sv
// Shared constants and types for the 240p suite input front-end.
package suite_pkg;

  localparam int LEVEL_W         = 4;
  localparam int LEVEL_MAX_DEF   = 10;
  localparam int LEVEL_RESET_DEF = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

endpackage

// File: rtl/suite_input_ctrl_if.sv
// Button/level bundle between the raw button source and the suite level consumer.
interface suite_input_ctrl_if
  import suite_pkg::*;
#(
  parameter int N_BTN = 12
) ();

  logic [N_BTN-1:0]   btn_raw;
  logic [N_BTN-1:0]   btn_state;
  logic [N_BTN-1:0]   btn_press;
  logic [LEVEL_W-1:0] level;
  logic               level_chg;

  modport master (
    output btn_raw,
    input  btn_state, btn_press, level, level_chg
  );

  modport slave (
    input  btn_raw,
    output btn_state, btn_press, level, level_chg
  );

endinterface

// File: rtl/suite_debounce.sv
// One button: 2-flop sync, stable-count debounce, registered rise pulse.
module suite_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic state,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      state <= 1'b0;
      press <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      press <= 1'b0;
      if (s2 == state) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        // Pulse rides with the flip so press and state rise together.
        state <= ~state;
        press <= ~state;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/suite_input_ctrl.sv
// Button conditioner and wrapping layer level for the 240p suite.
// Define SUITE_INPUT_AUTOREPEAT_EN to add hold-to-repeat on the UP/DN buttons.
module suite_input_ctrl
  import suite_pkg::*;
#(
  parameter int N_BTN           = 12,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LEVEL_MAX       = LEVEL_MAX_DEF,
  parameter int LEVEL_RESET     = LEVEL_RESET_DEF,
  parameter int UP_IDX          = 4,
  parameter int DN_IDX          = 5,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_RATE     = 4
) (
  input  logic              clk,
  input  logic              reset,
  suite_input_ctrl_if.slave bus
);

  if (DEBOUNCE_CYCLES < 1 || LEVEL_MAX > 15 || LEVEL_RESET > LEVEL_MAX ||
      REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
    $error("suite_input_ctrl: illegal parameter set");
  end

  logic [N_BTN-1:0]   btn_state;
  logic [N_BTN-1:0]   btn_press;
  logic [LEVEL_W-1:0] level;
  logic               level_chg;
  logic               rep_up, rep_dn;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    suite_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (bus.btn_raw[i]),
      .state (btn_state[i]),
      .press (btn_press[i])
    );
  end

`ifdef SUITE_INPUT_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RCW     = $clog2(RPT_MAX + 1);

  rpt_state_t     rpt_st, rpt_nxt;
  logic [RCW-1:0] rcnt, rcnt_nxt;
  logic           dir_up, dir_up_nxt;
  logic           rep, both_held, dir_held;

  assign both_held = btn_state[UP_IDX] & btn_state[DN_IDX];
  assign dir_held  = dir_up ? btn_state[UP_IDX] : btn_state[DN_IDX];

  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_st <= IDLE;
      rcnt   <= '0;
      dir_up <= 1'b0;
    end else begin
      rpt_st <= rpt_nxt;
      rcnt   <= rcnt_nxt;
      dir_up <= dir_up_nxt;
    end
  end

  always_comb begin
    rpt_nxt    = rpt_st;
    rcnt_nxt   = rcnt;
    dir_up_nxt = dir_up;
    rep        = 1'b0;
    if (both_held) begin
      rpt_nxt  = IDLE;
      rcnt_nxt = '0;
    end else begin
      case (rpt_st)
        IDLE: begin
          if (btn_press[UP_IDX] | btn_press[DN_IDX]) begin
            rpt_nxt    = DELAY;
            dir_up_nxt = btn_press[UP_IDX];
            rcnt_nxt   = '0;
          end
        end
        DELAY: begin
          if (!dir_held) begin
            rpt_nxt  = IDLE;
            rcnt_nxt = '0;
          end else if (rcnt == RCW'(REPEAT_DELAY - 1)) begin
            rep      = 1'b1;
            rpt_nxt  = REPEAT;
            rcnt_nxt = '0;
          end else begin
            rcnt_nxt = rcnt + RCW'(1);
          end
        end
        REPEAT: begin
          if (!dir_held) begin
            rpt_nxt  = IDLE;
            rcnt_nxt = '0;
          end else if (rcnt == RCW'(REPEAT_RATE - 1)) begin
            rep      = 1'b1;
            rcnt_nxt = '0;
          end else begin
            rcnt_nxt = rcnt + RCW'(1);
          end
        end
        default: begin
          rpt_nxt  = IDLE;
          rcnt_nxt = '0;
        end
      endcase
    end
  end

  assign rep_up = rep & dir_up;
  assign rep_dn = rep & ~dir_up;
`else
  assign rep_up = 1'b0;
  assign rep_dn = 1'b0;
`endif

  logic up, dn;
  assign up = btn_press[UP_IDX] | rep_up;
  assign dn = btn_press[DN_IDX] | rep_dn;

  always_ff @(posedge clk) begin
    if (reset) begin
      level     <= LEVEL_W'(LEVEL_RESET);
      level_chg <= 1'b0;
    end else begin
      level_chg <= 1'b0;
      // Simultaneous up and down cancel out entirely.
      if (up & ~dn) begin
        level     <= (level == LEVEL_W'(LEVEL_MAX)) ? '0 : level + LEVEL_W'(1);
        level_chg <= 1'b1;
      end else if (dn & ~up) begin
        level     <= (level == '0) ? LEVEL_W'(LEVEL_MAX) : level - LEVEL_W'(1);
        level_chg <= 1'b1;
      end
    end
  end

  assign bus.btn_state = btn_state;
  assign bus.btn_press = btn_press;
  assign bus.level     = level;
  assign bus.level_chg = level_chg;

endmodule

// File: tb/tb_suite_input_ctrl.sv
// Directed + random bench for suite_input_ctrl against a time-based reference model.
module tb_suite_input_ctrl;
  import suite_pkg::*;

  localparam int N_BTN = 12;
  localparam int DB    = 4;
  localparam int LMAX  = 10;
  localparam int LRST  = 10;
  localparam int UP    = 4;
  localparam int DN    = 5;
  localparam int RDLY  = 8;
  localparam int RRATE = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  suite_input_ctrl_if #(.N_BTN(N_BTN)) bus ();

  suite_input_ctrl #(
    .N_BTN(N_BTN), .DEBOUNCE_CYCLES(DB), .LEVEL_MAX(LMAX), .LEVEL_RESET(LRST),
    .UP_IDX(UP), .DN_IDX(DN), .REPEAT_DELAY(RDLY), .REPEAT_RATE(RRATE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model: raw is seen two edges late; a bit is accepted once its
  // last DB delayed samples all disagree with the accepted level.
  logic [N_BTN-1:0] m_d1, m_d2, m_state, m_press;
  logic [N_BTN-1:0] s2q[$];
  int               m_level, m_chg, m_cyc;
  bit               act, act_up;
  int               act_p;

  task automatic model_edge();
    logic [N_BTN-1:0] s2cur, flip;
    bit up, dn, rep, all_diff;
    int e;
    if (reset) begin
      m_d1 = '0; m_d2 = '0; s2q.delete();
      m_state = '0; m_press = '0; m_level = LRST; m_chg = 0; act = 0;
      m_cyc++;
      return;
    end
    s2cur = m_d2;
    m_d2  = m_d1;
    m_d1  = bus.btn_raw;
    s2q.push_back(s2cur);
    if (s2q.size() > DB) void'(s2q.pop_front());
    flip = '0;
    if (s2q.size() == DB)
      for (int b = 0; b < N_BTN; b++) begin
        all_diff = 1;
        foreach (s2q[j]) if (s2q[j][b] == m_state[b]) all_diff = 0;
        flip[b] = all_diff;
      end
    rep = 0;
`ifdef SUITE_INPUT_AUTOREPEAT_EN
    if (m_state[UP] && m_state[DN]) act = 0;
    else if (act && !m_state[act_up ? UP : DN]) act = 0;
    else if (act) begin
      e = m_cyc - act_p;
      if (e >= RDLY && ((e - RDLY) % RRATE) == 0) rep = 1;
    end else if (m_press[UP] || m_press[DN]) begin
      act = 1; act_up = m_press[UP]; act_p = m_cyc;
    end
`else
    e = 0;
`endif
    up = m_press[UP] | (rep & act_up);
    dn = m_press[DN] | (rep & ~act_up);
    m_chg = 0;
    if (up && !dn) begin m_level = (m_level + 1) % (LMAX + 1); m_chg = 1; end
    else if (dn && !up) begin m_level = (m_level + LMAX) % (LMAX + 1); m_chg = 1; end
    m_press = flip & ~m_state;
    m_state = m_state ^ flip;
    m_cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, m_cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("btn_state", 32'(bus.btn_state), 32'(m_state));
    chk("btn_press", 32'(bus.btn_press), 32'(m_press));
    chk("level", 32'(bus.level), 32'(m_level));
    chk("level_chg", 32'(bus.level_chg), 32'(m_chg));
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, k, lv0, chg_cnt;
    bus.btn_raw = '0;
    m_cyc = 0; m_level = LRST; m_state = '0; m_press = '0; act = 0; act_up = 0; act_p = 0;
    steps(3);
    reset = 1'b0;
    step();
    chk("rst_level", 32'(bus.level), 32'(LRST));
    chk("rst_state", 32'(bus.btn_state), 32'd0);
    chk("rst_press", 32'(bus.btn_press), 32'd0);
    chk("rst_chg", 32'(bus.level_chg), 32'd0);

    // Clean UP press: pulse in cycle 6, wrap 10->0 in cycle 7.
    bus.btn_raw[UP] = 1'b1;
    steps(5);
    chk("up_press_early", 32'(bus.btn_press[UP]), 32'd0);
    step();
    chk("up_press_c6", 32'(bus.btn_press[UP]), 32'd1);
    step();
    chk("up_press_c7", 32'(bus.btn_press[UP]), 32'd0);
    chk("up_wrap_level", 32'(bus.level), 32'd0);
    chk("up_wrap_chg", 32'(bus.level_chg), 32'd1);
    step();
    bus.btn_raw[UP] = 1'b0;
    steps(10);

    // Glitch train shorter than the debounce window.
    lv0 = m_level;
    bus.btn_raw[UP] = 1'b1; steps(3);
    bus.btn_raw[UP] = 1'b0; step();
    bus.btn_raw[UP] = 1'b1; steps(3);
    bus.btn_raw[UP] = 1'b0; steps(8);
    chk("glitch_state", 32'(bus.btn_state[UP]), 32'd0);
    chk("glitch_level", 32'(bus.level), 32'(lv0));

    // DN from 0 wraps to LEVEL_MAX.
    bus.btn_raw[DN] = 1'b1; steps(7);
    chk("dn_wrap_level", 32'(bus.level), 32'(LMAX));
    step();
    bus.btn_raw[DN] = 1'b0; steps(10);

    // UP and DN together: both pulse, no level change.
    bus.btn_raw[UP] = 1'b1; bus.btn_raw[DN] = 1'b1;
    steps(6);
    chk("both_press", 32'(bus.btn_press[DN:UP]), 32'd3);
    step();
    chk("both_level", 32'(bus.level), 32'(LMAX));
    chk("both_chg", 32'(bus.level_chg), 32'd0);
    bus.btn_raw[UP] = 1'b0; bus.btn_raw[DN] = 1'b0; steps(10);

`ifdef SUITE_INPUT_AUTOREPEAT_EN
    // Walk to level 3, then hold UP 30 cycles.
    for (int p = 0; p < 4; p++) begin
      bus.btn_raw[UP] = 1'b1; steps(8);
      bus.btn_raw[UP] = 1'b0; steps(8);
    end
    chk("rpt_start_level", 32'(bus.level), 32'd3);
    bus.btn_raw[UP] = 1'b1; steps(7);
    chk("rpt_first", 32'(bus.level), 32'd4);
    steps(8);
    chk("rpt_after_delay", 32'(bus.level), 32'd5);
    steps(4);
    chk("rpt_rate1", 32'(bus.level), 32'd6);
    steps(4);
    chk("rpt_rate2", 32'(bus.level), 32'd7);
    steps(7);
    bus.btn_raw[UP] = 1'b0;
    steps(6);
    lv0 = m_level;
    steps(10);
    chk("rpt_stopped", 32'(bus.level), 32'(lv0));
`endif

    // Reset while UP is held deep into a hold; a fresh press follows.
    bus.btn_raw[UP] = 1'b1; steps(20);
    reset = 1'b1; steps(2);
    reset = 1'b0;
    step();
    chk("rst_hold_level", 32'(bus.level), 32'(LRST));
    steps(5);
    chk("rst_hold_press", 32'(bus.btn_press[UP]), 32'd1);
    step();
    chk("rst_hold_step", 32'(bus.level), 32'd0);
    bus.btn_raw[UP] = 1'b0; steps(10);

    // Random button activity biased toward UP/DN, with rare resets.
    chg_cnt = 0;
    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(0, 99);
      if (r < 6) bus.btn_raw[UP] = ~bus.btn_raw[UP];
      else if (r < 12) bus.btn_raw[DN] = ~bus.btn_raw[DN];
      else if (r < 15) begin
        k = $urandom_range(0, N_BTN - 1);
        bus.btn_raw[k] = ~bus.btn_raw[k];
      end
      reset = ($urandom_range(0, 299) == 0);
      step();
      if (bus.level_chg) chg_cnt++;
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
